// File: rtl/placar_display.sv
// Multiplexed 4-digit scoreboard driver with tentos LEDs, blink highlighting of score changes
// (enabled by defining PLACAR_DISPLAY_HIGHLIGHT_EN) and a blinking match-over display.
module placar_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pontuacaoA,
  input  logic [3:0] pontuacaoB,
  input  logic [1:0] tentosA,
  input  logic [1:0] tentosB,
  input  logic       jogo_encerrado,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [2:0] led_tA,
  output logic [2:0] led_tB,
  output logic       led_fim
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  localparam logic [3:0] SYM_DASH  = 4'hE;
  localparam logic [3:0] SYM_BLANK = 4'hF;

`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
  typedef enum logic [1:0] {ST_NORMAL, ST_HIGHLIGHT, ST_FINAL} state_t;
`else
  typedef enum logic [1:0] {ST_NORMAL, ST_FINAL} state_t;
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] sym);
    case (sym)
      4'd0:     seg_code = 7'h40;
      4'd1:     seg_code = 7'h79;
      4'd2:     seg_code = 7'h24;
      4'd3:     seg_code = 7'h30;
      4'd4:     seg_code = 7'h19;
      4'd5:     seg_code = 7'h12;
      4'd6:     seg_code = 7'h02;
      4'd7:     seg_code = 7'h78;
      4'd8:     seg_code = 7'h00;
      4'd9:     seg_code = 7'h10;
      SYM_DASH: seg_code = 7'h3F;
      default:  seg_code = 7'h7F;
    endcase
  endfunction

  // Scores above 12 are treated as uninitialised and shown as a dash on both digits.
  function automatic logic [3:0] digit_sym(input logic [3:0] score, input logic tens);
    if (score > 4'd12)       digit_sym = SYM_DASH;
    else if (tens)           digit_sym = (score >= 4'd10) ? 4'd1 : SYM_BLANK;
    else if (score >= 4'd10) digit_sym = score - 4'd10;
    else                     digit_sym = score;
  endfunction

  function automatic logic [2:0] therm(input logic [1:0] t);
    case (t)
      2'd0:    therm = 3'b000;
      2'd1:    therm = 3'b001;
      2'd2:    therm = 3'b011;
      default: therm = 3'b111;
    endcase
  endfunction

  // Sampled inputs; all decoding below looks only at these.
  logic [3:0] pa_q, pa_d, pb_q, pb_d;
  logic [1:0] ta_q, ta_d, tb_q, tb_d;
  logic       fim_in_q, fim_in_d;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  state_t             state_q, state_d;

  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic [2:0] led_ta_q, led_ta_d, led_tb_q, led_tb_d;
  logic       led_fim_q, led_fim_d;

  logic       blink_wrap, final_off, blank_a, blank_b;
  logic [3:0] sym;

`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
  logic [3:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d;
  logic [1:0] mask_q, mask_d;
  logic [1:0] half_q, half_d;
  logic [1:0] chg;
`endif

  // NOTE: every *_d gets a default first, so no path through this block can infer a latch.
  always_comb begin
    pa_d        = pontuacaoA;
    pb_d        = pontuacaoB;
    ta_d        = tentosA;
    tb_d        = tentosB;
    fim_in_d    = jogo_encerrado;
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    state_d     = state_q;
    blink_wrap  = (blink_cnt_q == BLINK_MAX);

    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    if (state_q != ST_NORMAL) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      if (blink_wrap) phase_d = ~phase_q;
    end

`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
    prev_a_d = pa_q;
    prev_b_d = pb_q;
    mask_d   = mask_q;
    half_d   = half_q;
    chg      = {pa_q != prev_a_q, pb_q != prev_b_q};
    if (state_q == ST_HIGHLIGHT && blink_wrap) half_d = half_q + 2'd1;
`endif

    // Match-over wins over any score change and is left only through reset.
    if (fim_in_q && state_q != ST_FINAL) begin
      state_d     = ST_FINAL;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
    else if (state_q != ST_FINAL && chg != 2'b00) begin
      state_d     = ST_HIGHLIGHT;
      mask_d      = ((state_q == ST_HIGHLIGHT) ? mask_q : 2'b00) | chg;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
      half_d      = 2'd0;
    end else if (state_q == ST_HIGHLIGHT && blink_wrap && half_q == 2'd3) begin
      state_d = ST_NORMAL;
      mask_d  = 2'b00;
    end
`endif

    final_off = (state_q == ST_FINAL) && !phase_q;
    blank_a   = final_off;
    blank_b   = final_off;
`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
    if (state_q == ST_HIGHLIGHT && !phase_q) begin
      blank_a = blank_a | mask_q[1];
      blank_b = blank_b | mask_q[0];
    end
`endif

    // Index 0..3 drives an[0..3]: B units, B tens, A units, A tens.
    case (idx_q)
      2'd0:    sym = blank_b ? SYM_BLANK : digit_sym(pb_q, 1'b0);
      2'd1:    sym = blank_b ? SYM_BLANK : digit_sym(pb_q, 1'b1);
      2'd2:    sym = blank_a ? SYM_BLANK : digit_sym(pa_q, 1'b0);
      default: sym = blank_a ? SYM_BLANK : digit_sym(pa_q, 1'b1);
    endcase

    seg_d     = seg_code(sym);
    an_d      = ~(4'b0001 << idx_q);
    led_ta_d  = final_off ? 3'b000 : therm(ta_q);
    led_tb_d  = final_off ? 3'b000 : therm(tb_q);
    led_fim_d = (state_q == ST_FINAL);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pa_q        <= '0;
      pb_q        <= '0;
      ta_q        <= '0;
      tb_q        <= '0;
      fim_in_q    <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      state_q     <= ST_NORMAL;
      seg_q       <= 7'h7F;
      an_q        <= 4'hF;
      led_ta_q    <= 3'b000;
      led_tb_q    <= 3'b000;
      led_fim_q   <= 1'b0;
`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
      prev_a_q    <= '0;
      prev_b_q    <= '0;
      mask_q      <= 2'b00;
      half_q      <= 2'd0;
`endif
    end else begin
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      ta_q        <= ta_d;
      tb_q        <= tb_d;
      fim_in_q    <= fim_in_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      led_ta_q    <= led_ta_d;
      led_tb_q    <= led_tb_d;
      led_fim_q   <= led_fim_d;
`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
      prev_a_q    <= prev_a_d;
      prev_b_q    <= prev_b_d;
      mask_q      <= mask_d;
      half_q      <= half_d;
`endif
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign led_tA  = led_ta_q;
  assign led_tB  = led_tb_q;
  assign led_fim = led_fim_q;

endmodule

// File: tb/tb_placar_display.sv
// Randomized bench for placar_display against an event-time reference model (SCAN_DIV=2, BLINK_DIV=8);
// follows PLACAR_DISPLAY_HIGHLIGHT_EN when defined for the build.
module tb_placar_display;

  localparam int SD = 2;
  localparam int BD = 8;
`ifdef PLACAR_DISPLAY_HIGHLIGHT_EN
  localparam bit HL_EN = 1'b1;
`else
  localparam bit HL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] pa;
    logic [3:0] pb;
    logic [1:0] ta;
    logic [1:0] tb;
    logic       fim;
  } in_t;

  typedef enum {M_NORMAL, M_HL, M_FINAL} mode_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] led_tA, led_tB;
  logic       led_fim;

  in_t   drv;     // inputs presented to the next edge
  in_t   r1, r2;  // what was presented one and two edges ago
  mode_t mode;
  int    start;   // edge at which the current blink mode began
  logic [1:0] mask;
  int    n;       // edges since reset release
  int    total = 0;
  int    bad = 0;

  placar_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst),
    .pontuacaoA(drv.pa), .pontuacaoB(drv.pb),
    .tentosA(drv.ta), .tentosB(drv.tb),
    .jogo_encerrado(drv.fim),
    .seg(seg), .an(an), .led_tA(led_tA), .led_tB(led_tB), .led_fim(led_fim)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_digit(input int score, input bit tens);
    if (score > 12) return 7'h3F;
    if (tens) return (score >= 10) ? enc(1) : 7'h7F;
    return enc(score % 10);
  endfunction

  function automatic logic [2:0] exp_therm(input int t);
    return 3'((1 << t) - 1);
  endfunction

  task automatic model_reset();
    n = 0; r1 = '0; r2 = '0; mode = M_NORMAL; mask = 2'b00; start = 0;
  endtask

  // One clock edge: predict the outputs from the pre-edge picture, advance the model, compare at negedge.
  task automatic step(input string tag);
    int idx, k;
    bit off, blank_all, blank_a, blank_b;
    logic [1:0] chg;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [2:0] e_la, e_lb;
    logic e_fim;
    @(posedge clk);
    n++;
    idx       = ((n - 1) / SD) % 4;
    k         = n - 1 - start;
    off       = ((k / BD) % 2) == 0;
    blank_all = (mode == M_FINAL) && off;
    blank_a   = blank_all || (mode == M_HL && off && mask[1]);
    blank_b   = blank_all || (mode == M_HL && off && mask[0]);
    case (idx)
      0:       e_seg = blank_b ? 7'h7F : exp_digit(int'(r1.pb), 1'b0);
      1:       e_seg = blank_b ? 7'h7F : exp_digit(int'(r1.pb), 1'b1);
      2:       e_seg = blank_a ? 7'h7F : exp_digit(int'(r1.pa), 1'b0);
      default: e_seg = blank_a ? 7'h7F : exp_digit(int'(r1.pa), 1'b1);
    endcase
    e_an  = ~(4'b0001 << idx);
    e_la  = blank_all ? 3'b000 : exp_therm(int'(r1.ta));
    e_lb  = blank_all ? 3'b000 : exp_therm(int'(r1.tb));
    e_fim = (mode == M_FINAL);

    chg = {r1.pa != r2.pa, r1.pb != r2.pb};
    if (r1.fim && mode != M_FINAL) begin
      mode = M_FINAL; start = n;
    end else if (HL_EN && mode != M_FINAL && chg != 2'b00) begin
      mask = ((mode == M_HL) ? mask : 2'b00) | chg;
      mode = M_HL; start = n;
    end else if (mode == M_HL && n - start == 4 * BD) begin
      mode = M_NORMAL; mask = 2'b00;
    end
    r2 = r1;
    r1 = drv;

    @(negedge clk);
    total += 5;
    if (seg !== e_seg) begin
      bad++; $display("FAIL %s seg edge=%0d got=%h want=%h", tag, n, seg, e_seg);
    end
    if (an !== e_an) begin
      bad++; $display("FAIL %s an edge=%0d got=%h want=%h", tag, n, an, e_an);
    end
    if (led_tA !== e_la) begin
      bad++; $display("FAIL %s led_tA edge=%0d got=%b want=%b", tag, n, led_tA, e_la);
    end
    if (led_tB !== e_lb) begin
      bad++; $display("FAIL %s led_tB edge=%0d got=%b want=%b", tag, n, led_tB, e_lb);
    end
    if (led_fim !== e_fim) begin
      bad++; $display("FAIL %s led_fim edge=%0d got=%b want=%b", tag, n, led_fim, e_fim);
    end
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  // Asserts reset between edges and checks the outputs collapse before any clock arrives.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({seg, an, led_tA, led_tB, led_fim} !== {7'h7F, 4'hF, 3'b000, 3'b000, 1'b0}) begin
      bad++;
      $display("FAIL %s async_reset got seg=%h an=%h la=%b lb=%b fim=%b want 7f f 000 000 0",
               tag, seg, an, led_tA, led_tB, led_fim);
    end
    drv = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drv = '0;
    rst = 1'b0;
    #13;
    total++;
    if ({seg, an, led_tA, led_tB, led_fim} !== {7'h7F, 4'hF, 3'b000, 3'b000, 1'b0}) begin
      bad++;
      $display("FAIL reset_values got seg=%h an=%h la=%b lb=%b fim=%b", seg, an, led_tA, led_tB, led_fim);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step("reset_first");
    total++;
    if (an !== 4'hE) begin
      bad++; $display("FAIL reset_first_an got=%h want=e", an);
    end
    run("reset_scan", 16);
  endtask

  task automatic test_scores();
    drv.pa = 4'd11; drv.pb = 4'd5; drv.ta = 2'd1; drv.tb = 2'd3;
    run("score_11_5", 48);
    drv.pa = 4'd12; drv.pb = 4'd10;
    run("score_12_10", 48);
  endtask

  task automatic test_illegal();
    drv.pa = 4'd15; drv.tb = 2'd2;
    run("illegal_a15", 48);
    drv.pb = 4'd13; drv.pa = 4'd0;
    run("illegal_b13", 48);
  endtask

  task automatic test_highlight();
    drv.pa = 4'd3; drv.pb = 4'd7;
    run("hl_setup", 48);
    drv.pa = 4'd4;
    run("hl_a_3to4", 48);
    drv.pa = 4'd5; drv.pb = 4'd8;
    run("hl_both", 12);
    drv.pb = 4'd9;
    run("hl_retrigger", 48);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) drv.pa = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) drv.pb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  drv.ta = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  drv.tb = 2'($urandom_range(0, 3));
      step("random");
    end
  endtask

  task automatic test_final();
    drv.pa = 4'd6; drv.ta = 2'd2; drv.tb = 2'd1;
    run("final_pre", 5);
    drv.fim = 1'b1;
    run("final_enter", 40);
    drv.pa = 4'd7;
    run("final_change", 40);
    async_reset("final_abort");
    run("final_after_reset", 10);
  endtask

  task automatic test_reset_mid_highlight();
    drv.pb = 4'd2; drv.ta = 2'd3;
    run("mid_hl", 6);
    async_reset("hl_abort");
    run("hl_after_reset", 12);
  endtask

  initial begin
    test_reset();
    test_scores();
    test_illegal();
    test_highlight();
    test_random();
    test_reset_mid_highlight();
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
